// File: rtl/ascon_aead128_pkg.sv
// Shared definitions for the Ascon-AEAD128 data path: segment type encoding,
// rate geometry and the input packer state machine.
package ascon_aead128_pkg;

  // Segment type carried alongside every byte and every block.
  localparam logic AD_MODE = 1'b1;
  localparam logic AE_MODE = 1'b0;

  // Ascon 10* padding starts with this byte, followed by zeros.
  localparam logic [7:0] PAD_BYTE   = 8'h01;
  localparam int         RATE_BYTES = 16;

  typedef enum logic [1:0] {
    fill     = 2'd0,
    emit     = 2'd1,
    emit_pad = 2'd2
  } packer_fsm_state;

endpackage

// File: rtl/ascon_input_packer.sv
// Packs an AD / data byte stream into 128-bit little-endian rate blocks,
// inserts 10* padding on the final block of a segment and hands the blocks
// to the core over a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its payload stable while valid is high and
// ready is low; ready never depends on valid in the same cycle.
module ascon_input_packer
  import ascon_aead128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         din_last,
  input  logic         din_type,
  input  logic         din_empty,
  output logic [127:0] blk,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_type,
  output logic         blk_last,
  output logic [4:0]   blk_bytes,
  output logic         blk_empty,
  output logic [1:0]   o_dbg_state
);

  packer_fsm_state r_state;
  logic [3:0]      r_cnt;
  logic [127:0]    r_buf;
  logic            r_pad_pending;
  logic            r_blk_type;
  logic            r_blk_last;
  logic [4:0]      r_blk_bytes;
  logic            r_blk_empty;

  packer_fsm_state w_state_nx;
  logic [3:0]      w_cnt_nx;
  logic [127:0]    w_buf_nx;
  logic            w_pad_pending_nx;
  logic            w_blk_type_nx;
  logic            w_blk_last_nx;
  logic [4:0]      w_blk_bytes_nx;
  logic            w_blk_empty_nx;
  logic            w_din_ready;
  logic            w_accept;

  // Input is open only while filling; held closed during reset so nothing
  // is taken before the state register has been initialised.
  assign w_din_ready = (r_state == fill) && rst_n;
  assign w_accept    = din_valid && w_din_ready;

  assign din_ready   = w_din_ready;
  assign blk_valid   = (r_state == emit) || (r_state == emit_pad);
  assign blk         = r_buf;
  assign blk_type    = r_blk_type;
  assign blk_last    = r_blk_last;
  assign blk_bytes   = r_blk_bytes;
  assign blk_empty   = r_blk_empty;
  assign o_dbg_state = r_state;

  // Next-state logic: lane writes with pad insertion while filling, block
  // release (or follow-on pad block) on the output handshake.
  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_buf_nx         = r_buf;
    w_pad_pending_nx = r_pad_pending;
    w_blk_type_nx    = r_blk_type;
    w_blk_last_nx    = r_blk_last;
    w_blk_bytes_nx   = r_blk_bytes;
    w_blk_empty_nx   = r_blk_empty;

    case (r_state)
      fill: begin
        if (w_accept) begin
          if (r_cnt == 4'd0) w_blk_type_nx = din_type;
          if (din_empty) begin
            // Zero-length segment: a block made of padding only.
            w_buf_nx       = '0;
            w_buf_nx[7:0]  = PAD_BYTE;
            w_blk_bytes_nx = 5'd0;
            w_blk_last_nx  = 1'b1;
            w_blk_empty_nx = 1'b1;
            w_state_nx     = emit;
          end else begin
            for (int i = 0; i < RATE_BYTES; i++) begin
              if (4'(i) == r_cnt) begin
                w_buf_nx[8*i +: 8] = din;
              end else if (din_last && (r_cnt != 4'd15) && (4'(i) == r_cnt + 4'd1)) begin
                w_buf_nx[8*i +: 8] = PAD_BYTE;
              end else if (din_last && (4'(i) > r_cnt)) begin
                w_buf_nx[8*i +: 8] = 8'h00;
              end
            end
            if (din_last || (r_cnt == 4'd15)) begin
              // A final byte landing in lane 15 leaves no room for the pad,
              // so the pad goes out as a separate block afterwards.
              w_blk_bytes_nx   = {1'b0, r_cnt} + 5'd1;
              w_blk_last_nx    = din_last && (r_cnt != 4'd15);
              w_pad_pending_nx = din_last && (r_cnt == 4'd15);
              w_blk_empty_nx   = 1'b0;
              w_state_nx       = emit;
            end else begin
              w_cnt_nx = r_cnt + 4'd1;
            end
          end
        end
      end

      emit: begin
        if (blk_ready) begin
          if (r_pad_pending) begin
            w_buf_nx         = '0;
            w_buf_nx[7:0]    = PAD_BYTE;
            w_blk_bytes_nx   = 5'd0;
            w_blk_last_nx    = 1'b1;
            w_blk_empty_nx   = 1'b0;
            w_pad_pending_nx = 1'b0;
            w_state_nx       = emit_pad;
          end else begin
            w_buf_nx       = '0;
            w_cnt_nx       = 4'd0;
            w_blk_bytes_nx = 5'd0;
            w_blk_last_nx  = 1'b0;
            w_blk_empty_nx = 1'b0;
            w_state_nx     = fill;
          end
        end
      end

      emit_pad: begin
        if (blk_ready) begin
          w_buf_nx       = '0;
          w_cnt_nx       = 4'd0;
          w_blk_bytes_nx = 5'd0;
          w_blk_last_nx  = 1'b0;
          w_blk_empty_nx = 1'b0;
          w_state_nx     = fill;
        end
      end

      default: begin
        w_state_nx = fill;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial or pending block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= fill;
      r_cnt         <= 4'd0;
      r_buf         <= '0;
      r_pad_pending <= 1'b0;
      r_blk_type    <= AE_MODE;
      r_blk_last    <= 1'b0;
      r_blk_bytes   <= 5'd0;
      r_blk_empty   <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_buf         <= w_buf_nx;
      r_pad_pending <= w_pad_pending_nx;
      r_blk_type    <= w_blk_type_nx;
      r_blk_last    <= w_blk_last_nx;
      r_blk_bytes   <= w_blk_bytes_nx;
      r_blk_empty   <= w_blk_empty_nx;
    end
  end

endmodule

// File: tb/tb_ascon_input_packer.sv
// Bench for ascon_input_packer: byte segments are driven, the expected
// blocks are queued from a small reference model, and every block handed
// out is popped and compared.
module tb_ascon_input_packer;
  import ascon_aead128_pkg::*;

  localparam int W = 136; // {blk, type, last, bytes, empty}

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_ready;
  logic         din_last;
  logic         din_type;
  logic         din_empty;
  logic [127:0] blk;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_type;
  logic         blk_last;
  logic [4:0]   blk_bytes;
  logic         blk_empty;
  logic [1:0]   dbg_state;

  ascon_input_packer dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .din_last(din_last), .din_type(din_type), .din_empty(din_empty),
    .blk(blk), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_type(blk_type), .blk_last(blk_last), .blk_bytes(blk_bytes),
    .blk_empty(blk_empty), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int n_seen = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stall 5 cycles per block
  int stall_cnt = 0;
  logic hold_v = 1'b0;
  logic [W-1:0] hold_val;
  wire  [W-1:0] act_w = {blk, blk_type, blk_last, blk_bytes, blk_empty};

  function automatic logic [W-1:0] pack_exp(input logic [127:0] b, input logic t,
                                            input logic l, input logic [4:0] n, input logic e);
    return {b, t, l, n, e};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: split a segment into rate blocks with 10* padding.
  function automatic void model_push(input logic typ, input int len, input logic [7:0] d[64]);
    logic [127:0] b;
    int pos;
    int rem;
    pos = 0;
    if (len == 0) begin
      exp_q.push_back(pack_exp(128'h01, typ, 1'b1, 5'd0, 1'b1));
      return;
    end
    while (len - pos >= 16) begin
      b = '0;
      for (int j = 0; j < 16; j++) b[8*j +: 8] = d[pos+j];
      exp_q.push_back(pack_exp(b, typ, 1'b0, 5'd16, 1'b0));
      pos += 16;
    end
    rem = len - pos;
    b = '0;
    for (int j = 0; j < rem; j++) b[8*j +: 8] = d[pos+j];
    b[8*rem +: 8] = 8'h01;
    exp_q.push_back(pack_exp(b, typ, 1'b1, 5'(rem), 1'b0));
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) begin
        check("hold_valid", {135'd0, blk_valid}, 1);
        check("hold_stable", act_w, hold_val);
      end
      if (blk_valid) check("din_ready_low", {135'd0, din_ready}, 0);
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got %h expected none", act_w);
        end else begin
          check("block", act_w, exp_q.pop_front());
        end
        n_seen++;
      end
      hold_v   = blk_valid && !blk_ready;
      hold_val = act_w;
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- blk_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: blk_ready = 1'b1;
      1: blk_ready = 1'($urandom_range(0, 1));
      default: begin
        if (blk_valid && stall_cnt < 5) begin
          blk_ready = 1'b0;
          stall_cnt++;
        end else begin
          blk_ready = blk_valid;
          stall_cnt = 0;
        end
      end
    endcase
  end

  // ---------------- input protocol assertions ----------------
  int  lane = 0;
  logic seg_type = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      lane = 0;
    end else if (din_valid && din_ready) begin
      assert (!(din_empty && lane != 0)) else $error("protocol violation: empty marker mid-block");
      assert (!(lane != 0 && din_type != seg_type)) else $error("protocol violation: type change mid-segment");
      if (lane == 0) seg_type = din_type;
      if (din_empty || din_last || lane == 15) lane = 0;
      else lane = lane + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [7:0] b, input logic typ, input logic last,
                            input logic empty, input bit chk_lat);
    int  k;
    bit  acc;
    k   = 0;
    acc = 1'b0;
    din = b; din_type = typ; din_last = last; din_empty = empty; din_valid = 1'b1;
    while (!acc && k < 500) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      k++;
    end
    din_valid = 1'b0; din_last = 1'b0; din_empty = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL din_timeout: got no din_ready expected accept within 500 cycles");
    end else if (chk_lat) begin
      check("latency_valid", {135'd0, blk_valid}, 1);
    end
  endtask

  task automatic drive_seg(input logic typ, input int len, input logic [7:0] d[64]);
    if (len == 0) begin
      drive_beat(8'h00, typ, 1'b1, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < len; i++)
        drive_beat(d[i], typ, (i == len-1), 1'b0, (i == len-1) || (i % 16 == 15));
    end
  endtask

  task automatic wait_drain(input int exp_blocks);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
      exp_q.delete();
    end
    check("block_count", W'(n_seen), W'(exp_blocks));
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic typ;
    int   len;
    int   first;
    int   mode;
    int   nblk;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] data[64];

  initial begin
    vecs[0] = '{AE_MODE, 16, 8'h10, 0, 2};  // full block + separate pad block
    vecs[1] = '{AE_MODE, 20, 8'h40, 2, 2};  // stalled output, 4-byte tail
    vecs[2] = '{AE_MODE, 15, 8'h01, 0, 1};  // pad lands in lane 15
    vecs[3] = '{AD_MODE, 1,  8'hEE, 2, 1};
    vecs[4] = '{AE_MODE, 33, 8'h80, 1, 3};
    vecs[5] = '{AD_MODE, 32, 8'hA0, 1, 3};
    vecs[6] = '{AD_MODE, 0,  8'h00, 2, 1};  // empty AD under stall

    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; din_last = 1'b0;
    din_type = AE_MODE; din_empty = 1'b0; blk_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", {135'd0, din_ready}, 0);
    check("rst_outputs", act_w, pack_exp(128'h0, AE_MODE, 1'b0, 5'd0, 1'b0));
    check("rst_blk_valid", {135'd0, blk_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_din_ready", {135'd0, din_ready}, 1);
    @(posedge clk);
    #1;

    // Hand-written: 5 AD bytes 0x00..0x04
    for (int i = 0; i < 64; i++) data[i] = 8'(i);
    n_seen = 0;
    exp_q.push_back(pack_exp(128'h01_0403020100, AD_MODE, 1'b1, 5'd5, 1'b0));
    drive_seg(AD_MODE, 5, data);
    wait_drain(1);

    // Hand-written: empty AD marker
    n_seen = 0;
    exp_q.push_back(pack_exp(128'h01, AD_MODE, 1'b1, 5'd0, 1'b1));
    drive_seg(AD_MODE, 0, data);
    wait_drain(1);

    // Table-driven segments
    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].mode;
      for (int i = 0; i < 64; i++) data[i] = 8'(vecs[v].first + i);
      n_seen = 0;
      model_push(vecs[v].typ, vecs[v].len, data);
      drive_seg(vecs[v].typ, vecs[v].len, data);
      wait_drain(vecs[v].nblk);
    end

    // Hand-written: reset after 7 bytes discards the partial block
    rdy_mode = 0;
    for (int i = 0; i < 7; i++) drive_beat(8'(8'h50 + i), AE_MODE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_din_ready", {135'd0, din_ready}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_cleared", act_w, pack_exp(128'h0, AE_MODE, 1'b0, 5'd0, 1'b0));
    check("midrst_blk_valid", {135'd0, blk_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", {135'd0, din_ready}, 1);
    @(posedge clk);
    #1;
    n_seen = 0;
    exp_q.push_back(pack_exp(128'h01_626160, AE_MODE, 1'b1, 5'd3, 1'b0));
    for (int i = 0; i < 3; i++) drive_beat(8'(8'h60 + i), AE_MODE, (i == 2), 1'b0, (i == 2));
    wait_drain(1);

    // Random segments with random back-pressure
    rdy_mode = 1;
    for (int r = 0; r < 12; r++) begin
      int   len;
      logic typ;
      len = $urandom_range(0, 64);
      typ = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) data[i] = 8'($urandom_range(0, 255));
      n_seen = 0;
      model_push(typ, len, data);
      drive_seg(typ, len, data);
      wait_drain((len == 0) ? 1 : (len / 16 + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
